// File: rtl/mix_seq_ctrl.sv
// Mix-layer pass sequencer: walks the bias/weight ROM addresses and the MAC
// accumulator strobes in lock-step for one MIX layer, after a pipeline fill.
module mix_seq_ctrl #(
    parameter int unsigned HID_DIM  = 24,
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned BEATS    = 4,
    parameter int unsigned PIPE_LAT = 8,
    parameter int unsigned B_ADDR_W = 7,
    parameter int unsigned W_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          layer,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [B_ADDR_W-1:0] bias_addr,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                acc_clr,
    output logic                acc_en,
    output logic                bias_en,
    output logic [B_ADDR_W-1:0] out_idx
);

    localparam int unsigned ROW_W  = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned FILL_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [BEAT_W-1:0]   beat;
    logic [FILL_W-1:0]   fill_cnt;
    logic [B_ADDR_W-1:0] base;

    logic [ROW_W-1:0]    run_row;
    logic [BEAT_W-1:0]   run_beat;
    logic [B_ADDR_W-1:0] start_base;
    logic [B_ADDR_W-1:0] cur_base;
    logic [31:0]         row_addr;
    logic                layer_ok;
    logic                last_beat;
    logic                last_row;
    logic                enter_run;

    // run_row/run_beat are the counter values shown in the next RUN cycle, so the
    // registered outputs can be loaded from them on the same edge.
    always_comb begin
        layer_ok   = 32'(layer) < N_LAYERS;
        start_base = B_ADDR_W'(32'(layer) * HID_DIM);
        cur_base   = (state == IDLE) ? start_base : base;
        last_beat  = (beat == BEAT_W'(BEATS - 1));
        last_row   = (row == ROW_W'(HID_DIM - 1));
        run_row    = '0;
        run_beat   = '0;
        if (state == RUN) begin
            if (last_beat) begin
                run_row = row + 1'b1;
            end else begin
                run_row  = row;
                run_beat = beat + 1'b1;
            end
        end
        row_addr  = 32'(cur_base) + 32'(run_row);
        enter_run = 1'b0;
        case (state)
            IDLE:    enter_run = start && layer_ok && (PIPE_LAT == 0);
            FILL:    enter_run = (fill_cnt == FILL_W'(PIPE_LAT));
            RUN:     enter_run = !(last_row && last_beat);
            default: enter_run = 1'b0;
        endcase
        if (abort) begin
            enter_run = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            beat      <= '0;
            fill_cnt  <= '0;
            base      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bias_addr <= '0;
            w_addr    <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            bias_en   <= 1'b0;
            out_idx   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            row       <= '0;
            beat      <= '0;
            fill_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bias_addr <= '0;
            w_addr    <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            bias_en   <= 1'b0;
            out_idx   <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            acc_clr <= 1'b0;
            acc_en  <= 1'b0;
            bias_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (layer_ok) begin
                            base <= start_base;
                            row  <= '0;
                            beat <= '0;
                            busy <= 1'b1;
                            if (PIPE_LAT == 0) begin
                                state <= RUN;
                            end else begin
                                state     <= FILL;
                                fill_cnt  <= FILL_W'(1);
                                bias_addr <= start_base;
                                w_addr    <= W_ADDR_W'(32'(start_base) * BEATS);
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_cnt == FILL_W'(PIPE_LAT)) begin
                        state <= RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (last_row && last_beat) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        row       <= '0;
                        beat      <= '0;
                        bias_addr <= '0;
                        w_addr    <= '0;
                        out_idx   <= '0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    fill_cnt <= '0;
                end
                default: state <= IDLE;
            endcase

            // Shared load for every edge that leads into a RUN cycle.
            if (enter_run) begin
                row       <= run_row;
                beat      <= run_beat;
                bias_addr <= B_ADDR_W'(row_addr);
                w_addr    <= W_ADDR_W'(row_addr * BEATS + 32'(run_beat));
                out_idx   <= B_ADDR_W'(run_row);
                acc_en    <= 1'b1;
                acc_clr   <= (run_beat == '0);
                bias_en   <= (run_beat == BEAT_W'(BEATS - 1));
            end
        end
    end

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Directed bench for mix_seq_ctrl: default configuration plus a short
// PIPE_LAT=0 / HID_DIM=2 / BEATS=1 instance.
module tb_mix_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] layer;
    logic       abort;
    logic       busy, done, err, acc_clr, acc_en, bias_en;
    logic [6:0] bias_addr, out_idx;
    logic [9:0] w_addr;

    logic       start2;
    logic [1:0] layer2;
    logic       abort2;
    logic       busy2, done2, err2, acc_clr2, acc_en2, bias_en2;
    logic [6:0] bias_addr2, out_idx2;
    logic [9:0] w_addr2;

    int checks;
    int failures;

    mix_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer), .abort(abort),
        .busy(busy), .done(done), .err(err), .bias_addr(bias_addr), .w_addr(w_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .bias_en(bias_en), .out_idx(out_idx)
    );

    mix_seq_ctrl #(.HID_DIM(2), .N_LAYERS(3), .BEATS(1), .PIPE_LAT(0),
                   .B_ADDR_W(7), .W_ADDR_W(10)) dut_short (
        .clk(clk), .rst_n(rst_n), .start(start2), .layer(layer2), .abort(abort2),
        .busy(busy2), .done(done2), .err(err2), .bias_addr(bias_addr2), .w_addr(w_addr2),
        .acc_clr(acc_clr2), .acc_en(acc_en2), .bias_en(bias_en2), .out_idx(out_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 0; layer = 0; abort = 0;
        start2 = 0; layer2 = 0; abort2 = 0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL reset_main got=%h exp=0",
                     {busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx});
        end
        checks++;
        if ({busy2, done2, err2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL reset_short got=%h exp=0",
                     {busy2, done2, err2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_layer1();
        logic [6:0] exp_bias;
        logic [9:0] exp_w;
        logic       exp_clr, exp_ben;
        int         n_ben;
        n_ben = 0;
        start = 1; layer = 2'd1;
        tick();
        start = 0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({busy, done, acc_clr, acc_en, bias_en, bias_addr, w_addr} !== {5'b10000, 7'd24, 10'd96}) begin
                failures++;
                $display("[TB] FAIL fill_cycle%0d got=%h exp=%h", k,
                         {busy, done, acc_clr, acc_en, bias_en, bias_addr, w_addr},
                         {5'b10000, 7'd24, 10'd96});
            end
            tick();
        end
        for (int i = 0; i < 96; i++) begin
            exp_bias = 7'(24 + i / 4);
            exp_w    = 10'(96 + i);
            exp_clr  = (i % 4 == 0);
            exp_ben  = (i % 4 == 3);
            checks++;
            if ({busy, done, acc_clr, acc_en, bias_en, bias_addr, w_addr} !==
                {1'b1, 1'b0, exp_clr, 1'b1, exp_ben, exp_bias, exp_w}) begin
                failures++;
                $display("[TB] FAIL run_beat%0d got=%h exp=%h", i,
                         {busy, done, acc_clr, acc_en, bias_en, bias_addr, w_addr},
                         {1'b1, 1'b0, exp_clr, 1'b1, exp_ben, exp_bias, exp_w});
            end
            if (exp_ben) begin
                checks++;
                if (out_idx !== 7'(n_ben)) begin
                    failures++;
                    $display("[TB] FAIL out_idx%0d got=%0d exp=%0d", i, out_idx, n_ben);
                end
                n_ben++;
            end
            tick();
        end
        checks++;
        if ({busy, done, acc_en, bias_en} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL done_at_105 got=%b exp=1100", {busy, done, acc_en, bias_en});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_after_done got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_invalid_layer();
        start = 1; layer = 2'd3;
        tick();
        start = 0;
        checks++;
        if ({err, busy, bias_addr, w_addr} !== {2'b10, 17'd0}) begin
            failures++;
            $display("[TB] FAIL bad_layer_err got=%h exp=%h", {err, busy, bias_addr, w_addr}, {2'b10, 17'd0});
        end
        tick();
        checks++;
        if ({err, busy, bias_addr, w_addr} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL bad_layer_after got=%h exp=0", {err, busy, bias_addr, w_addr});
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        start = 1; layer = 2'd0;
        tick();
        for (int k = 1; k <= 104; k++) begin
            if ({busy, done, err} !== 3'b100) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL held_start_busy got=%0d bad cycles exp=0", bad);
        end
        checks++;
        if ({busy, done} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL held_start_done got=%b exp=11", {busy, done});
        end
        tick();
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL gap_cycle got=%b exp=000", {busy, done, err});
        end
        tick();
        checks++;
        if ({busy, acc_en, bias_addr, w_addr} !== {2'b10, 17'd0}) begin
            failures++;
            $display("[TB] FAIL second_pass_fill got=%h exp=%h", {busy, acc_en, bias_addr, w_addr}, {2'b10, 17'd0});
        end
        start = 0; abort = 1;
        tick();
        abort = 0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_in_fill got=%b exp=0", busy);
        end
    endtask

    task automatic test_abort();
        int bad;
        start = 1; layer = 2'd2;
        tick();
        start = 0;
        for (int k = 1; k < 31; k++) tick();
        checks++;
        if ({acc_clr, acc_en, bias_en, bias_addr, w_addr} !== {3'b010, 7'd53, 10'd214}) begin
            failures++;
            $display("[TB] FAIL row5_beat2 got=%h exp=%h", {acc_clr, acc_en, bias_en, bias_addr, w_addr},
                     {3'b010, 7'd53, 10'd214});
        end
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if ({busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL abort_outputs got=%h exp=0",
                     {busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx});
        end
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if ({busy, done} !== 2'b00) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL no_done_after_abort got=%0d bad cycles exp=0", bad);
        end
        abort = 1; start = 1; layer = 2'd0;
        tick();
        abort = 0; start = 0;
        checks++;
        if ({busy, err, bias_addr} !== 9'd0) begin
            failures++;
            $display("[TB] FAIL abort_beats_start got=%h exp=0", {busy, err, bias_addr});
        end
        start = 1; layer = 2'd0;
        tick();
        start = 0;
        checks++;
        if ({busy, acc_en, bias_addr, w_addr} !== {2'b10, 17'd0}) begin
            failures++;
            $display("[TB] FAIL restart_fill got=%h exp=%h", {busy, acc_en, bias_addr, w_addr}, {2'b10, 17'd0});
        end
        for (int k = 1; k < 105; k++) tick();
        checks++;
        if ({busy, done} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL restart_done got=%b exp=11", {busy, done});
        end
        tick();
    endtask

    task automatic test_async_reset();
        start = 1; layer = 2'd1;
        tick();
        start = 0;
        for (int k = 1; k < 49; k++) tick();
        checks++;
        if ({acc_clr, acc_en, bias_addr, w_addr, out_idx} !== {2'b11, 7'd34, 10'd136, 7'd10}) begin
            failures++;
            $display("[TB] FAIL row10_entry got=%h exp=%h", {acc_clr, acc_en, bias_addr, w_addr, out_idx},
                     {2'b11, 7'd34, 10'd136, 7'd10});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h exp=0",
                     {busy, done, err, acc_clr, acc_en, bias_en, bias_addr, w_addr, out_idx});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, acc_en, bias_addr, w_addr} !== 20'd0) begin
            failures++;
            $display("[TB] FAIL after_reset_idle got=%h exp=0", {busy, done, acc_en, bias_addr, w_addr});
        end
    endtask

    task automatic test_short_config();
        start2 = 1; layer2 = 2'd1;
        tick();
        start2 = 0;
        checks++;
        if ({busy2, done2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2} !==
            {5'b10111, 7'd2, 10'd2, 7'd0}) begin
            failures++;
            $display("[TB] FAIL short_t1 got=%h exp=%h",
                     {busy2, done2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2},
                     {5'b10111, 7'd2, 10'd2, 7'd0});
        end
        tick();
        checks++;
        if ({busy2, done2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2} !==
            {5'b10111, 7'd3, 10'd3, 7'd1}) begin
            failures++;
            $display("[TB] FAIL short_t2 got=%h exp=%h",
                     {busy2, done2, acc_clr2, acc_en2, bias_en2, bias_addr2, w_addr2, out_idx2},
                     {5'b10111, 7'd3, 10'd3, 7'd1});
        end
        tick();
        checks++;
        if ({busy2, done2, acc_en2, bias_en2} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL short_done got=%b exp=1100", {busy2, done2, acc_en2, bias_en2});
        end
        tick();
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL short_idle got=%b exp=00", {busy2, done2});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pass_layer1();
        test_invalid_layer();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_short_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
